// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the streaming 2-D convolution engine.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      OUT     = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   // Counter width for a range of `depth` values; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned depth);
      return (clog2(depth) == 0) ? 1 : clog2(depth);
   endfunction

   function automatic int unsigned acc_width(input int unsigned dw, input int unsigned k);
      return 2 * dw + clog2(k * k);
   endfunction

   function automatic int unsigned nout_of(input int unsigned n, input int unsigned k);
      return n - k + 1;
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Unsigned DW x DW multiply-accumulate with synchronous clear and enable.
module conv_mac #(
   parameter int unsigned DW   = 8,
   parameter int unsigned ACCW = 20
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr,
   input  logic            en,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [ACCW-1:0] acc
);

   logic [2*DW-1:0] prod;

   assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + ACCW'(prod);
      end
   end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 2-D convolution/correlation engine: buffered image and kernel,
// one K*K-cycle MAC pass per valid output, results in raster order.
module conv2d_stream_engine
   import conv_pkg::*;
#(
   parameter int unsigned DW  = 8,
   parameter int unsigned N   = 4,
   parameter int unsigned K   = 3,
   parameter int unsigned SAT = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_sel,
   input  logic [DW-1:0] in_data,
   input  logic          run,
   input  logic          flip,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [DW-1:0] o_data,
   output logic          busy,
   output logic          done
);

   localparam int unsigned KK   = K * K;
   localparam int unsigned NN   = N * N;
   localparam int unsigned ACCW = acc_width(DW, K);
   localparam int unsigned NOUT = nout_of(N, K);
   localparam int unsigned KAW  = idx_width(KK);
   localparam int unsigned NAW  = idx_width(NN);
   localparam int unsigned SW   = idx_width(K);
   localparam int unsigned OW   = idx_width(NOUT);

   state_t state, state_nxt;

   logic [DW-1:0]   kbuf [KK];
   logic [DW-1:0]   ibuf [NN];
   logic [KAW-1:0]  kcnt;
   logic [NAW-1:0]  icnt;
   logic            k_loaded, i_loaded;
   logic            flip_q, clr_phase, done_q;
   logic [SW-1:0]   mi, mj;
   logic [OW-1:0]   r, c;
   logic [KAW-1:0]  kaddr;
   logic [NAW-1:0]  iaddr;
   logic [ACCW-1:0] acc;
   logic            accept_in, start, mac_last, win_last, o_fire;
   logic            mac_clr, mac_en;

   assign accept_in = in_valid && (state == IDLE);
   assign start     = run && (state == IDLE) && k_loaded && i_loaded;
   assign mac_last  = (mi == SW'(K - 1)) && (mj == SW'(K - 1));
   assign win_last  = (r == OW'(NOUT - 1)) && (c == OW'(NOUT - 1));
   assign o_fire    = (state == OUT) && o_ready;
   assign mac_clr   = (state == COMPUTE) && clr_phase;
   assign mac_en    = (state == COMPUTE) && !clr_phase;

   // Rotating the kernel by 180 degrees is just reversing its linear index.
   assign kaddr = flip_q ? KAW'((K - 1 - mi) * K + (K - 1 - mj))
                         : KAW'(mi * K + mj);
   assign iaddr = NAW'((r + mi) * N + c + mj);

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign o_valid  = (state == OUT);
   assign done     = done_q;

   always_comb begin
      o_data = '0;
      if (state == OUT) begin
         if ((SAT != 0) && (|acc[ACCW-1:DW])) o_data = '1;
         else                                 o_data = acc[DW-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = COMPUTE;
         COMPUTE: if (!clr_phase && mac_last) state_nxt = OUT;
         OUT:     if (o_ready) state_nxt = win_last ? IDLE : COMPUTE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned x = 0; x < KK; x++) kbuf[x] <= '0;
         for (int unsigned x = 0; x < NN; x++) ibuf[x] <= '0;
         kcnt      <= '0;
         icnt      <= '0;
         k_loaded  <= 1'b0;
         i_loaded  <= 1'b0;
         flip_q    <= 1'b0;
         clr_phase <= 1'b0;
         done_q    <= 1'b0;
         mi        <= '0;
         mj        <= '0;
         r         <= '0;
         c         <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept_in) begin
            if (in_sel) begin
               ibuf[icnt] <= in_data;
               if (icnt == NAW'(NN - 1)) begin
                  icnt     <= '0;
                  i_loaded <= 1'b1;
               end else begin
                  icnt <= icnt + 1'b1;
               end
            end else begin
               kbuf[kcnt] <= in_data;
               if (kcnt == KAW'(KK - 1)) begin
                  kcnt     <= '0;
                  k_loaded <= 1'b1;
               end else begin
                  kcnt <= kcnt + 1'b1;
               end
            end
         end
         if (start) begin
            flip_q    <= flip;
            clr_phase <= 1'b1;
            mi        <= '0;
            mj        <= '0;
            r         <= '0;
            c         <= '0;
         end
         // First COMPUTE cycle only clears the accumulator; MACs follow.
         if (state == COMPUTE) begin
            if (clr_phase) begin
               clr_phase <= 1'b0;
            end else if (mj == SW'(K - 1)) begin
               mj <= '0;
               mi <= (mi == SW'(K - 1)) ? '0 : mi + 1'b1;
            end else begin
               mj <= mj + 1'b1;
            end
         end
         if (o_fire) begin
            clr_phase <= 1'b1;
            if (win_last) begin
               r      <= '0;
               c      <= '0;
               done_q <= 1'b1;
            end else if (c == OW'(NOUT - 1)) begin
               c <= '0;
               r <= r + 1'b1;
            end else begin
               c <= c + 1'b1;
            end
         end
      end
   end

   conv_mac #(
      .DW   (DW),
      .ACCW (ACCW)
   ) u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (ibuf[iaddr]),
      .b     (kbuf[kaddr]),
      .acc   (acc)
   );

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine: wrap-around and saturating
// instances driven in lockstep with hand-computed expected results.
module tb_conv2d_stream_engine;

   typedef int vec4_t  [4];
   typedef int vec9_t  [9];
   typedef int vec16_t [16];

   logic       clk, reset;
   logic       in_valid, in_sel, run, flip, o_ready;
   logic [7:0] in_data;
   logic       in_ready, o_valid, busy, done;
   logic [7:0] o_data;
   logic       in_ready1, o_valid1, busy1, done1;
   logic [7:0] o_data1;

   int errors = 0;
   int checks = 0;

   vec16_t img1 = '{3, 1, 6, 5, 7, 5, 2, 7, 7, 10, 8, 9, 1, 3, 2, 10};
   vec9_t  ker1 = '{3, 1, 4, 0, 5, 1, 0, 1, 5};
   vec4_t  res1 = '{110, 101, 110, 121};
   vec16_t img2 = '{72, 58, 36, 24, 254, 210, 159, 73, 89, 72, 205, 101, 220, 9, 87, 172};
   vec9_t  ker2 = '{201, 170, 24, 59, 109, 187, 80, 141, 210};
   vec4_t  res2 = '{248, 3, 137, 121};
   vec4_t  sat2 = '{255, 255, 255, 255};
   vec9_t  ones = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
   vec4_t  res3 = '{49, 53, 45, 56};

   conv2d_stream_engine #(.DW(8), .N(4), .K(3), .SAT(0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_data(in_data), .run(run), .flip(flip),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
      .busy(busy), .done(done)
   );

   conv2d_stream_engine #(.DW(8), .N(4), .K(3), .SAT(1)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .in_sel(in_sel), .in_data(in_data), .run(run), .flip(flip),
      .o_valid(o_valid1), .o_ready(o_ready), .o_data(o_data1),
      .busy(busy1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send_beat(input logic sel, input int data);
      in_sel   = sel;
      in_data  = 8'(data);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic load_kernel(input vec9_t k);
      for (int i = 0; i < 9; i++) send_beat(1'b0, k[i]);
   endtask

   task automatic load_image(input vec16_t im);
      for (int i = 0; i < 16; i++) send_beat(1'b1, im[i]);
   endtask

   task automatic start_job(input logic f);
      run  = 1'b1;
      flip = f;
      @(negedge clk);
      run  = 1'b0;
   endtask

   task automatic collect(input string tag, input vec4_t e0, input vec4_t e1);
      int n;
      o_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!o_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!o_valid) begin
            chk($sformatf("%s_timeout[%0d]", tag, k), 32'(o_valid), 32'd1);
            return;
         end
         chk($sformatf("%s[%0d]", tag, k), 32'(o_data), 32'(e0[k]));
         chk($sformatf("%s_sat[%0d]", tag, k), 32'(o_data1), 32'(e1[k]));
         @(negedge clk);
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int stable;
      bit ok;

      reset    = 1'b0;
      in_valid = 1'b0;
      in_sel   = 1'b0;
      in_data  = '0;
      run      = 1'b0;
      flip     = 1'b0;
      o_ready  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_data", 32'(o_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Run with only the kernel loaded must be ignored.
      load_kernel(ker1);
      start_job(1'b1);
      ok = 1'b1;
      repeat (12) begin
         if (busy || o_valid || !in_ready) ok = 1'b0;
         @(negedge clk);
      end
      chk("run_ignored_no_image", 32'(ok), 32'd1);

      load_image(img1);
      start_job(1'b1);
      chk("busy_after_run", 32'(busy), 32'd1);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      n = 0;
      while (!o_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("first_latency", 32'(n), 32'd10);
      collect("conv", res1, res1);

      // Backpressure with an image beat offered while busy.
      o_ready = 1'b0;
      start_job(1'b1);
      n = 0;
      while (!o_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b1;
      in_sel   = 1'b1;
      in_data  = 8'd99;
      stable   = 0;
      repeat (20) begin
         @(negedge clk);
         if (o_valid && o_data == 8'd110) stable++;
      end
      in_valid = 1'b0;
      chk("bp_hold", 32'(stable), 32'd20);
      collect("bp", res1, res1);

      load_kernel(ones);
      start_job(1'b0);
      collect("corr", res3, res3);
      start_job(1'b1);
      collect("rot", res3, res3);

      load_kernel(ker2);
      load_image(img2);
      start_job(1'b1);
      collect("big", res2, sat2);

      // Reset during the fifth MAC cycle.
      start_job(1'b1);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_o_valid", 32'(o_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_o_data", 32'(o_data), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      start_job(1'b1);
      ok = 1'b1;
      repeat (15) begin
         if (busy || o_valid) ok = 1'b0;
         @(negedge clk);
      end
      chk("run_ignored_after_abort", 32'(ok), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
